npu_tile_scheduler: RTL and testbench

- Upstream sequencer for the tile processor.
- Accepts matrix-operation commands from the host/control path into a small command FIFO.
- Expands each command into a row-major walk over a rectangular range of 8x8-grid tile coordinates, issuing one start per tile and waiting for that tile's completion before issuing the next.
- Reports per-command completion, a running tile count, and malformed-command errors.

---
 rtl/npu_tile_scheduler.sv | 174 +++++++++++++++++
 tb/tb_npu_tile_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_tile_scheduler.sv
// Tile scheduler: buffers host commands in a small FIFO and walks each command's tile range row-major,
// issuing one tile-processor start per tile. Optional WAIT watchdog enabled by defining NPU_SCHED_TIMEOUT_EN.
module npu_tile_scheduler #(
   parameter int QDEPTH = 4,
   parameter int CNT_W  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [2:0]       cmd_i0,
   input  logic [2:0]       cmd_i1,
   input  logic [2:0]       cmd_j0,
   input  logic [2:0]       cmd_j1,
   output logic             tp_start,
   output logic [2:0]       tp_tile_i,
   output logic [2:0]       tp_tile_j,
   output logic [2:0]       tp_op_code,
   input  logic             tp_done,
   output logic             busy,
   output logic             cmd_done,
   output logic             cmd_err,
   output logic [CNT_W-1:0] tiles_done
);
   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

   typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, NEXT} state_t;
   typedef struct packed {
      logic [2:0] op;
      logic [2:0] i0;
      logic [2:0] i1;
      logic [2:0] j0;
      logic [2:0] j1;
   } cmd_t;

   cmd_t             fifoMem [QDEPTH];
   logic [AW-1:0]    wrPtr_q, rdPtr_q;
   logic [AW:0]      count_q;
   logic             readyEn_q;
   logic             tpDone_q;
   state_t           state_q;
   cmd_t             work_q;
   logic [2:0]       curI_q, curJ_q, opCode_q;
   logic             start_q, done_q, err_q;
   logic [CNT_W-1:0] tiles_q;
`ifdef NPU_SCHED_TIMEOUT_EN
   logic [15:0]      wdog_q;
`endif

   logic push, pop, empty, full, doneEdge;
   cmd_t cmdIn;

   assign cmdIn    = '{op: cmd_op, i0: cmd_i0, i1: cmd_i1, j0: cmd_j0, j1: cmd_j1};
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign push     = cmd_valid && cmd_ready;
   assign pop      = (state_q == IDLE) && !empty;
   assign doneEdge = tp_done && !tpDone_q;

   // readyEn_q keeps cmd_ready low while reset is asserted.
   assign cmd_ready  = readyEn_q && !full;
   assign busy       = (state_q != IDLE) || !empty;
   assign tp_start   = start_q;
   assign tp_tile_i  = curI_q;
   assign tp_tile_j  = curJ_q;
   assign tp_op_code = opCode_q;
   assign cmd_done   = done_q;
   assign cmd_err    = err_q;
   assign tiles_done = tiles_q;

   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr_q] <= cmdIn;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         readyEn_q <= 1'b0;
         tpDone_q  <= 1'b0;
      end else begin
         readyEn_q <= 1'b1;
         tpDone_q  <= tp_done;
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // Outputs are loaded on entry to ISSUE so tp_start is high during the ISSUE cycle itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         work_q   <= '0;
         curI_q   <= '0;
         curJ_q   <= '0;
         opCode_q <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         tiles_q  <= '0;
`ifdef NPU_SCHED_TIMEOUT_EN
         wdog_q   <= '0;
`endif
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  work_q  <= fifoMem[rdPtr_q];
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               if (work_q.op > 3'd4 || work_q.i0 > work_q.i1 || work_q.j0 > work_q.j1) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  curI_q   <= work_q.i0;
                  curJ_q   <= work_q.j0;
                  opCode_q <= work_q.op;
                  start_q  <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef NPU_SCHED_TIMEOUT_EN
               wdog_q  <= '0;
`endif
               state_q <= WAIT;
            end
            WAIT: begin
               if (doneEdge) begin
                  tiles_q <= tiles_q + 1'b1;
                  state_q <= NEXT;
               end
`ifdef NPU_SCHED_TIMEOUT_EN
               else if (wdog_q == 16'hFFFF) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wdog_q <= wdog_q + 16'd1;
               end
`endif
            end
            NEXT: begin
               if (curJ_q < work_q.j1) begin
                  curJ_q  <= curJ_q + 1'b1;
                  start_q <= 1'b1;
                  state_q <= ISSUE;
               end else if (curI_q < work_q.i1) begin
                  curI_q  <= curI_q + 1'b1;
                  curJ_q  <= work_q.j0;
                  start_q <= 1'b1;
                  state_q <= ISSUE;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Directed testbench for npu_tile_scheduler: a tile-processor responder model plus per-scenario check tasks.
module tb_npu_tile_scheduler;
   localparam int QDEPTH = 4;
   localparam int CNT_W  = 7;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0, cmd_i0 = '0, cmd_i1 = '0, cmd_j0 = '0, cmd_j1 = '0;
   logic             tp_start;
   logic [2:0]       tp_tile_i, tp_tile_j, tp_op_code;
   logic             tp_done = 1'b0;
   logic             busy, cmd_done, cmd_err;
   logic [CNT_W-1:0] tiles_done;

   int vectors = 0;
   int miscompares = 0;
   int cycleCnt = 0;

   bit respEnable = 1'b1;
   bit respHold = 1'b0;
   int respDelay = 1;

   logic [2:0] startI[$], startJ[$], startOp[$];
   int         startCyc[$], doneCyc[$];
   int         errCount = 0;

   npu_tile_scheduler #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_i0(cmd_i0), .cmd_i1(cmd_i1), .cmd_j0(cmd_j0), .cmd_j1(cmd_j1),
      .tp_start(tp_start), .tp_tile_i(tp_tile_i), .tp_tile_j(tp_tile_j), .tp_op_code(tp_op_code),
      .tp_done(tp_done), .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .tiles_done(tiles_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor: logs every start, completion and error pulse with its cycle stamp.
   initial forever begin
      @(posedge clk); #1;
      if (tp_start) begin
         startI.push_back(tp_tile_i);
         startJ.push_back(tp_tile_j);
         startOp.push_back(tp_op_code);
         startCyc.push_back(cycleCnt);
      end
      if (cmd_done) doneCyc.push_back(cycleCnt);
      if (cmd_err) errCount++;
   end

   // Tile-processor model: raises done respDelay cycles after a start; in hold mode the level stays high
   // and is dropped at the next start.
   initial forever begin
      @(posedge clk); #1;
      if (tp_start && respEnable) begin
         if (respHold) tp_done = 1'b0;
         repeat (respDelay) @(posedge clk);
         #1 tp_done = 1'b1;
         if (!respHold) begin
            @(posedge clk);
            #1 tp_done = 1'b0;
         end
      end
   end

   task automatic pushCmd(input logic [2:0] op, i0, i1, j0, j1, output int acceptCyc);
      bit accepted;
      accepted = 1'b0;
      cmd_valid = 1'b1;
      cmd_op = op; cmd_i0 = i0; cmd_i1 = i1; cmd_j0 = j0; cmd_j1 = j1;
      for (int k = 0; k < 100 && !accepted; k++) begin
         accepted = cmd_ready;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      acceptCyc = cycleCnt;
      vectors++;
      if (!accepted) begin
         miscompares++;
         $display("[TB] FAIL push_accept op=%0d: accepted=0, required 1", op);
      end
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      vectors++;
      if (busy) begin
         miscompares++;
         $display("[TB] FAIL %s idle_timeout: busy=%0b, required 0", tag, busy);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({cmd_ready, busy, tp_start, cmd_done, cmd_err, tp_tile_i, tp_tile_j, tp_op_code, tiles_done} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: ready=%0b busy=%0b start=%0b tiles=%0d, required all 0",
                  cmd_ready, busy, tp_start, tiles_done);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ready_at_deassert: got %0b, required 0", cmd_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ready_after_reset: ready=%0b busy=%0b, required 1/0", cmd_ready, busy);
      end
   endtask

   task automatic test_single_tile();
      int sb, db, acc;
      sb = startCyc.size(); db = doneCyc.size();
      respEnable = 1'b1; respHold = 1'b0; respDelay = 10;
      pushCmd(3'd0, 3'd2, 3'd2, 3'd5, 3'd5, acc);
      waitIdle(200, "single");
      vectors++;
      if (startCyc.size() - sb != 1 || doneCyc.size() - db != 1) begin
         miscompares++;
         $display("[TB] FAIL single_counts: starts=%0d dones=%0d, required 1/1", startCyc.size() - sb, doneCyc.size() - db);
      end else begin
         vectors++;
         if ({startI[sb], startJ[sb], startOp[sb]} !== {3'd2, 3'd5, 3'd0}) begin
            miscompares++;
            $display("[TB] FAIL single_tile: got (%0d,%0d) op %0d, required (2,5) op 0", startI[sb], startJ[sb], startOp[sb]);
         end
         vectors++;
         if (startCyc[sb] - acc != 2) begin
            miscompares++;
            $display("[TB] FAIL pop_to_start: got %0d cycles, required 2", startCyc[sb] - acc);
         end
         vectors++;
         if (doneCyc[db] - startCyc[sb] != 12) begin
            miscompares++;
            $display("[TB] FAIL done_latency: got %0d cycles after start, required 12", doneCyc[db] - startCyc[sb]);
         end
      end
      vectors++;
      if (tiles_done !== 7'd1) begin
         miscompares++;
         $display("[TB] FAIL single_tiles_done: got %0d, required 1", tiles_done);
      end
   endtask

   task automatic test_multi_tile();
      int sb, db, acc, bad;
      logic [2:0] expI[4], expJ[4];
      expI = '{3'd0, 3'd0, 3'd1, 3'd1};
      expJ = '{3'd6, 3'd7, 3'd6, 3'd7};
      sb = startCyc.size(); db = doneCyc.size();
      respHold = 1'b0; respDelay = 3;
      pushCmd(3'd1, 3'd0, 3'd1, 3'd6, 3'd7, acc);
      waitIdle(200, "multi");
      vectors++;
      if (startCyc.size() - sb != 4 || doneCyc.size() - db != 1) begin
         miscompares++;
         $display("[TB] FAIL multi_counts: starts=%0d dones=%0d, required 4/1", startCyc.size() - sb, doneCyc.size() - db);
      end else begin
         bad = 0;
         for (int k = 0; k < 4; k++)
            if ({startI[sb+k], startJ[sb+k], startOp[sb+k]} !== {expI[k], expJ[k], 3'd1}) bad++;
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL multi_order: %0d starts out of order, required 0", bad);
         end
         vectors++;
         if (startCyc[sb+1] - startCyc[sb] != 5) begin
            miscompares++;
            $display("[TB] FAIL start_spacing: got %0d cycles, required 5", startCyc[sb+1] - startCyc[sb]);
         end
      end
      vectors++;
      if (tiles_done !== 7'd5) begin
         miscompares++;
         $display("[TB] FAIL multi_tiles_done: got %0d, required 5", tiles_done);
      end
   endtask

   task automatic test_full_grid();
      int sb, db, acc, bad;
      sb = startCyc.size(); db = doneCyc.size();
      respHold = 1'b1; respDelay = 1;
      pushCmd(3'd3, 3'd0, 3'd7, 3'd0, 3'd7, acc);
      waitIdle(2000, "grid");
      respHold = 1'b0;
      tp_done = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (startCyc.size() - sb != 64 || doneCyc.size() - db != 1) begin
         miscompares++;
         $display("[TB] FAIL grid_counts: starts=%0d dones=%0d, required 64/1", startCyc.size() - sb, doneCyc.size() - db);
      end else begin
         bad = 0;
         for (int k = 0; k < 64; k++)
            if ({startI[sb+k], startJ[sb+k], startOp[sb+k]} !== {3'(k / 8), 3'(k % 8), 3'd3}) bad++;
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL grid_order: %0d starts wrong, required 0", bad);
         end
         vectors++;
         if ({startI[sb+63], startJ[sb+63]} !== {3'd7, 3'd7}) begin
            miscompares++;
            $display("[TB] FAIL grid_last: got (%0d,%0d), required (7,7)", startI[sb+63], startJ[sb+63]);
         end
      end
      vectors++;
      if (tiles_done !== 7'd69) begin
         miscompares++;
         $display("[TB] FAIL grid_tiles_done: got %0d, required 69", tiles_done);
      end
   endtask

   task automatic test_illegal();
      int sb, db, eb, acc;
      sb = startCyc.size(); db = doneCyc.size(); eb = errCount;
      respDelay = 2;
      pushCmd(3'd6, 3'd0, 3'd0, 3'd0, 3'd0, acc);
      pushCmd(3'd2, 3'd3, 3'd1, 3'd0, 3'd0, acc);
      pushCmd(3'd4, 3'd4, 3'd4, 3'd4, 3'd4, acc);
      waitIdle(200, "illegal");
      vectors++;
      if (errCount - eb != 2) begin
         miscompares++;
         $display("[TB] FAIL err_pulses: got %0d, required 2", errCount - eb);
      end
      vectors++;
      if (startCyc.size() - sb != 1 || doneCyc.size() - db != 1) begin
         miscompares++;
         $display("[TB] FAIL illegal_counts: starts=%0d dones=%0d, required 1/1", startCyc.size() - sb, doneCyc.size() - db);
      end else begin
         vectors++;
         if ({startI[sb], startJ[sb], startOp[sb]} !== {3'd4, 3'd4, 3'd4}) begin
            miscompares++;
            $display("[TB] FAIL dot_tile: got (%0d,%0d) op %0d, required (4,4) op 4", startI[sb], startJ[sb], startOp[sb]);
         end
      end
      vectors++;
      if (tiles_done !== 7'd70) begin
         miscompares++;
         $display("[TB] FAIL illegal_tiles_done: got %0d, required 70", tiles_done);
      end
   endtask

   task automatic test_back_to_back();
      int sb, db, acc, bad, k;
      logic [2:0] expI[5], expJ[5], expOp[5];
      expI  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
      expJ  = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0};
      expOp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      sb = startCyc.size(); db = doneCyc.size();
      respEnable = 1'b0;
      pushCmd(expOp[0], expI[0], expI[0], expJ[0], expJ[0], acc);
      k = 0;
      while (startCyc.size() == sb && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      for (int n = 1; n < 5; n++) pushCmd(expOp[n], expI[n], expI[n], expJ[n], expJ[n], acc);
      vectors++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL fifo_full: ready=%0b busy=%0b, required 0/1", cmd_ready, busy);
      end
      respEnable = 1'b1; respDelay = 2;
      tp_done = 1'b1;
      @(posedge clk); #1;
      tp_done = 1'b0;
      waitIdle(300, "b2b");
      vectors++;
      if (startCyc.size() - sb != 5 || doneCyc.size() - db != 5) begin
         miscompares++;
         $display("[TB] FAIL b2b_counts: starts=%0d dones=%0d, required 5/5", startCyc.size() - sb, doneCyc.size() - db);
      end else begin
         bad = 0;
         for (int n = 0; n < 5; n++)
            if ({startI[sb+n], startJ[sb+n], startOp[sb+n]} !== {expI[n], expJ[n], expOp[n]}) bad++;
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_order: %0d starts wrong, required 0", bad);
         end
         vectors++;
         if (startCyc[sb+1] - doneCyc[db] != 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_done_to_start: got %0d cycles, required 2", startCyc[sb+1] - doneCyc[db]);
         end
      end
      vectors++;
      if (tiles_done !== 7'd75) begin
         miscompares++;
         $display("[TB] FAIL b2b_tiles_done: got %0d, required 75", tiles_done);
      end
   endtask

   task automatic test_reset_mid_command();
      int sb, db, acc, k;
      sb = startCyc.size(); db = doneCyc.size();
      respEnable = 1'b0;
      pushCmd(3'd0, 3'd0, 3'd1, 3'd0, 3'd1, acc);
      k = 0;
      while (startCyc.size() == sb && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      pushCmd(3'd1, 3'd6, 3'd6, 3'd6, 3'd6, acc);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({cmd_ready, busy, tp_start, cmd_done, cmd_err, tp_tile_i, tp_tile_j, tp_op_code, tiles_done} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: ready=%0b busy=%0b tiles=%0d, required all 0", cmd_ready, busy, tiles_done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      respEnable = 1'b1; respDelay = 1;
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (startCyc.size() - sb != 1 || doneCyc.size() != db) begin
         miscompares++;
         $display("[TB] FAIL midreset_discard: starts=%0d dones=%0d, required 1/0", startCyc.size() - sb, doneCyc.size() - db);
      end
      vectors++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || tiles_done !== 7'd0) begin
         miscompares++;
         $display("[TB] FAIL midreset_state: busy=%0b ready=%0b tiles=%0d, required 0/1/0", busy, cmd_ready, tiles_done);
      end
   endtask

   task automatic test_wrap();
      int sb, acc;
      sb = startCyc.size();
      respEnable = 1'b1; respHold = 1'b0; respDelay = 1;
      pushCmd(3'd0, 3'd0, 3'd7, 3'd0, 3'd7, acc);
      pushCmd(3'd1, 3'd0, 3'd7, 3'd0, 3'd7, acc);
      waitIdle(2000, "wrap");
      vectors++;
      if (startCyc.size() - sb != 128 || tiles_done !== 7'd0) begin
         miscompares++;
         $display("[TB] FAIL wrap_zero: starts=%0d tiles=%0d, required 128/0", startCyc.size() - sb, tiles_done);
      end
      pushCmd(3'd2, 3'd7, 3'd7, 3'd0, 3'd0, acc);
      waitIdle(100, "wrap_one");
      vectors++;
      if (tiles_done !== 7'd1) begin
         miscompares++;
         $display("[TB] FAIL wrap_one: got %0d, required 1", tiles_done);
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_multi_tile();
      test_full_grid();
      test_illegal();
      test_back_to_back();
      test_reset_mid_command();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
